// File: rtl/lisa_autobaud.sv
// Auto-baud trainer and 16x baud_ref generator feeding the lisa_rx8n receiver.
// Measures the start bit of a sync character whose LSB is 1, checks its stop bit, then runs baud_ref.
//
// state  | meaning
// RUN    | baud generator running, rxd_o follows the synchronized line
// ARM    | waiting for a falling edge of the synchronized line
// MEAS   | counting start-bit width
// VERIFY | waiting for the stop-bit centre before accepting the candidate divisor
module lisa_autobaud #(
  parameter int DIV_W   = 12,
  parameter int DEF_DIV = 10,
  parameter int MIN_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rxd,
  input  logic             start,
  input  logic             cfg_wr,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             baud_ref,
  output logic             rxd_o,
  output logic [DIV_W-1:0] div,
  output logic             busy,
  output logic             err
);

  localparam int MW = DIV_W + 4;
  localparam int VW = DIV_W + 8;
  localparam int QW = DIV_W + 5;

  typedef enum logic [1:0] {RUN, ARM, MEAS, VERIFY} state_t;

  state_t           state, state_n;
  logic             sync1, rxd_s, rxd_p;
  logic             fall, rise, reload;
  logic [MW-1:0]    meas, meas_n;
  logic [DIV_W-1:0] cand, cand_n, cnt, cnt_n, div_n, cfg_clamp;
  logic [VW-1:0]    vcnt, vcnt_n, vtarget;
  logic [QW-1:0]    q;
  logic             err_n, baud_n, q_bad;

  assign fall      = rxd_p & ~rxd_s;
  assign rise      = ~rxd_p & rxd_s;
  assign q         = (QW'(meas) + QW'(8)) >> 4;
  assign q_bad     = (q < QW'(MIN_DIV)) || (q > QW'({DIV_W{1'b1}}));
  // 9.5 bit times after the start edge, counted from the end of the start bit
  assign vtarget   = VW'({meas, 3'b000}) + VW'(meas >> 1) - VW'(1);
  assign cfg_clamp = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;

  always_comb begin
    state_n = state;
    meas_n  = meas;
    cand_n  = cand;
    vcnt_n  = vcnt;
    div_n   = div;
    cnt_n   = cnt;
    err_n   = err;
    baud_n  = 1'b0;
    reload  = 1'b0;

    if (cfg_wr) begin
      div_n   = cfg_clamp;
      err_n   = 1'b0;
      state_n = RUN;
      reload  = 1'b1;
    end else if (start) begin
      err_n   = 1'b0;
      state_n = ARM;
    end else begin
      case (state)
        RUN: ;
        ARM: begin
          if (fall) begin
            meas_n  = MW'(1);
            state_n = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            if (q_bad) begin
              err_n   = 1'b1;
              state_n = ARM;
            end else begin
              cand_n  = q[DIV_W-1:0];
              vcnt_n  = '0;
              state_n = VERIFY;
            end
          end else if (&meas) begin
            err_n   = 1'b1;
            state_n = ARM;
          end else if (!rxd_s) begin
            meas_n = meas + MW'(1);
          end
        end
        VERIFY: begin
          if (vcnt == vtarget) begin
            if (rxd_s) begin
              div_n   = cand;
              state_n = RUN;
              reload  = 1'b1;
            end else begin
              err_n   = 1'b1;
              state_n = ARM;
            end
          end else begin
            vcnt_n = vcnt + VW'(1);
          end
        end
        default: state_n = RUN;
      endcase
    end

    // the counter only advances while staying in RUN; entering RUN reloads it
    if (reload) begin
      cnt_n = div_n - DIV_W'(1);
    end else if (state == RUN && state_n == RUN) begin
      if (cnt == '0) begin
        baud_n = 1'b1;
        cnt_n  = div - DIV_W'(1);
      end else begin
        cnt_n = cnt - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      sync1    <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_p    <= 1'b1;
      meas     <= '0;
      cand     <= '0;
      vcnt     <= '0;
      div      <= DIV_W'(DEF_DIV);
      cnt      <= DIV_W'(DEF_DIV - 1);
      baud_ref <= 1'b0;
      rxd_o    <= 1'b1;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      sync1    <= rxd;
      rxd_s    <= sync1;
      rxd_p    <= rxd_s;
      meas     <= meas_n;
      cand     <= cand_n;
      vcnt     <= vcnt_n;
      div      <= div_n;
      cnt      <= cnt_n;
      baud_ref <= baud_n;
      rxd_o    <= (state_n == RUN) ? sync1 : 1'b1;
      busy     <= (state_n != RUN);
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_lisa_autobaud.sv
// Bench for lisa_autobaud: cycle-level behavioural model compared every cycle,
// plus directed literal checks for the trained divisors and priority cases.
module tb_lisa_autobaud;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic        start = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [11:0] cfg_div = '0;
  logic        baud_ref, rxd_o, busy, err;
  logic [11:0] div;

  lisa_autobaud dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .start(start), .cfg_wr(cfg_wr),
    .cfg_div(cfg_div), .baud_ref(baud_ref), .rxd_o(rxd_o), .div(div),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_RUN = 0, P_ARM = 1, P_MEAS = 2, P_VER = 3;
  int phase = P_RUN;
  int mdiv = 10;
  int t = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int target_cyc = 0;
  int cand = 0;
  bit merr = 0;
  bit exp_baud = 0, exp_rxdo = 1, exp_busy = 0;
  bit m_s1 = 1, m_s2 = 1, m_sp = 1;

  task automatic m_reset();
    phase = P_RUN; mdiv = 10; t = 0; merr = 0;
    exp_baud = 0; exp_rxdo = 1; exp_busy = 0;
    m_s1 = 1; m_s2 = 1; m_sp = 1;
  endtask

  task automatic m_step();
    bit rs, rp, fall, rise, reload;
    int np, k, q;
    rs = m_s2; rp = m_sp;
    fall = rp && !rs;
    rise = !rp && rs;
    reload = 0;
    np = phase;
    if (cfg_wr) begin
      mdiv = (cfg_div < 2) ? 2 : int'(cfg_div);
      merr = 0; np = P_RUN; reload = 1;
    end else if (start) begin
      merr = 0; np = P_ARM;
    end else begin
      case (phase)
        P_ARM: if (fall) begin fall_cyc = cyc; np = P_MEAS; end
        P_MEAS: begin
          k = cyc - fall_cyc;   // low cycles since the start edge
          if (rise) begin
            q = (k + 8) / 16;
            if (q < 2 || q > 4095) begin merr = 1; np = P_ARM; end
            else begin cand = q; target_cyc = cyc + 8 * k + k / 2; np = P_VER; end
          end else if (k >= 65535) begin
            merr = 1; np = P_ARM;
          end
        end
        P_VER: if (cyc == target_cyc) begin
          if (rs) begin mdiv = cand; np = P_RUN; reload = 1; end
          else begin merr = 1; np = P_ARM; end
        end
        default: ;
      endcase
    end
    if (np == P_RUN && phase == P_RUN && !reload) begin
      t++;
      exp_baud = (t % mdiv) == 0;
    end else begin
      exp_baud = 0;
      t = 0;
    end
    phase = np;
    m_sp = m_s2; m_s2 = m_s1; m_s1 = rxd;
    exp_rxdo = (phase == P_RUN) ? m_s2 : 1'b1;
    exp_busy = (phase != P_RUN);
    cyc++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) m_reset();
    else m_step();
  end

  initial forever begin
    @(negedge clk);
    chk("baud_ref", baud_ref, exp_baud);
    chk("rxd_o", rxd_o, exp_rxdo);
    chk("busy", busy, exp_busy);
    chk("err", err, merr);
    chk("div", div, mdiv);
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
  endtask

  task automatic idle(input int n);
    @(negedge clk); #1 rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // 8N1 character, n clocks per bit; bad_stop pulls the stop-bit centre low
  task automatic send_byte(input logic [7:0] b, input int n, input bit bad_stop);
    logic v;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      for (int j = 0; j < n; j++) begin
        @(negedge clk); #1;
        rxd = (bad_stop && i == 9 && j >= n / 2 - 8 && j <= n / 2 + 8) ? 1'b0 : v;
      end
    end
  endtask

  task automatic measure_period(output int p);
    int c;
    p = -1;
    c = 0;
    while (c < 5000) begin
      @(negedge clk); c++;
      if (baud_ref) break;
    end
    c = 0;
    while (c < 5000) begin
      @(negedge clk); c++;
      if (baud_ref) begin p = c; break; end
    end
  endtask

  initial begin
    int p, n;
    logic [7:0] b;
    bit bad;

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #3;
    chk("rst_div", div, 10);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_rxd_o", rxd_o, 1);
    measure_period(p);
    chk("rst_period", p, 10);

    // rxd_o follows rxd two clocks later
    @(negedge clk); #1 rxd = 1'b0;
    @(negedge clk); #3 chk("rxd_o_lat1", rxd_o, 1);
    @(negedge clk); #3 chk("rxd_o_lat2", rxd_o, 0);
    idle(30);

    // train at 160 clks/bit, then a data byte at the trained rate
    pulse_start();
    fork
      send_byte(8'h0D, 160, 0);
      begin
        repeat (400) @(negedge clk);
        #3;
        chk("train_busy", busy, 1);
        chk("train_rxd_o", rxd_o, 1);
        chk("train_baud", baud_ref, 0);
      end
    join
    chk("t160_div", div, 10);
    chk("t160_busy", busy, 0);
    chk("t160_err", err, 0);
    idle(20);
    send_byte(8'h55, 160, 0);
    idle(20);

    // train at 333 clks/bit
    pulse_start();
    send_byte(8'h0D, 333, 0);
    chk("t333_div", div, 21);
    measure_period(p);
    chk("t333_period", p, 21);

    // break: meas saturates, err sticks through a later good training
    pulse_start();
    @(negedge clk); #1 rxd = 1'b0;
    repeat (65700) @(negedge clk);
    #3;
    chk("brk_err", err, 1);
    chk("brk_busy", busy, 1);
    idle(40);
    send_byte(8'h0D, 160, 0);
    chk("brk_div", div, 10);
    chk("brk_err_sticky", err, 1);
    chk("brk_busy_done", busy, 0);
    idle(20);

    // stop bit low at its centre
    pulse_start();
    #2 chk("stop_err_clr", err, 0);
    send_byte(8'h0D, 160, 1);
    chk("stop_err", err, 1);
    chk("stop_busy", busy, 1);
    chk("stop_div", div, 10);
    idle(20);

    // cfg_wr and start together: cfg wins, divisor clamped
    @(negedge clk); #1 cfg_wr = 1'b1; cfg_div = 12'd1; start = 1'b1;
    @(negedge clk); #1 cfg_wr = 1'b0; start = 1'b0;
    #2;
    chk("clamp_div", div, 2);
    chk("clamp_busy", busy, 0);
    chk("clamp_err", err, 0);
    measure_period(p);
    chk("clamp_period", p, 2);

    // cfg_wr during MEAS aborts training
    pulse_start();
    fork
      send_byte(8'h0D, 80, 0);
      begin
        repeat (40) @(negedge clk);
        #1 cfg_wr = 1'b1; cfg_div = 12'd40;
        @(negedge clk); #1 cfg_wr = 1'b0;
        #2;
        chk("abort_div", div, 40);
        chk("abort_busy", busy, 0);
      end
    join
    idle(20);

    // async reset during VERIFY
    pulse_start();
    fork
      send_byte(8'h0D, 80, 0);
      begin
        repeat (300) @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (5) begin
          @(negedge clk); #3;
          chk("rstv_baud", baud_ref, 0);
          chk("rstv_div", div, 10);
        end
        rst_n = 1'b1;
      end
    join
    idle(20);

    // randomized trainings and manual loads
    for (int it = 0; it < 3; it++) begin
      n = $urandom_range(32, 100);
      b = 8'($urandom) | 8'h01;
      bad = ($urandom_range(0, 3) == 0);
      idle($urandom_range(5, 50));
      pulse_start();
      send_byte(b, n, bad);
      if (!bad) chk("rnd_div", div, (n + 8) / 16);
      idle($urandom_range(5, 30));
      send_byte(8'($urandom), n, 0);
      idle(20);
      n = $urandom_range(0, 30);
      @(negedge clk); #1 cfg_wr = 1'b1; cfg_div = 12'(n);
      @(negedge clk); #1 cfg_wr = 1'b0;
      #2 chk("rnd_cfg_div", div, (n < 2) ? 2 : n);
      repeat (60) @(negedge clk);
    end

    @(negedge clk); #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lisa_autobaud.md
Name: lisa_autobaud

Overview:
Auto-baud controller and 16x baud_ref generator for the lisa_rx8n receive path.
- On a start request it measures the start-bit width of a sync character whose LSB is 1 (e.g. 0x0D), derives a 16x divisor and validates the stop bit.
- It then runs baud_ref at the measured rate.
- While training it holds the receiver's rxd input idle-high, so the sync character never reaches the RX buffer.

Parameters:
DIV_W, 12, divisor width; the measurement counter is DIV_W+4 bits.
DEF_DIV, 10, divisor loaded at reset.
MIN_DIV, 2, smallest legal divisor; smaller results are rejected (training) or clamped (cfg_wr).

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
rxd  in  1  raw serial line, asynchronous, idle high
start  in  1  1-cycle pulse: begin auto-baud training
cfg_wr  in  1  1-cycle pulse: load cfg_div directly, abort any training
cfg_div  in  DIV_W  manual divisor
baud_ref  out  1  1-clk pulse every div clocks (16x bit rate), to lisa_rx8n baud_ref
rxd_o  out  1  line to lisa_rx8n rxd: rxd_s in RUN, forced 1 otherwise
div  out  DIV_W  active divisor
busy  out  1  1 while training (states ARM, MEAS, VERIFY)
err  out  1  sticky training failure; cleared by start or cfg_wr

Behaviour:
- rxd passes through a 2-flop synchronizer, giving rxd_s. All edge detection uses rxd_s versus its previous value, so both edges carry the same 2-cycle delay.
- Reset values: state RUN, div=DEF_DIV, baud counter=DEF_DIV-1, baud_ref=0, rxd_o=1, busy=0, err=0, synchronizer flops=1.
- States:
  - RUN: baud generator active; rxd_o=rxd_s. start -> ARM, clear err.
  - ARM: waits for a falling edge of rxd_s. A falling edge requires a prior-cycle 1, so arming while the line is low waits for idle first. On the edge: meas=1 -> MEAS.
  - MEAS: meas increments each cycle rxd_s=0.
    - Rising edge: compute q=(meas+8)>>4 in DIV_W+5 bits.
      - q<MIN_DIV or q>2^DIV_W-1: err=1 -> ARM.
      - Otherwise: store q as cand, vcnt=0 -> VERIFY.
    - meas reaching all-ones (timeout or break): err=1 -> ARM.
  - VERIFY: vcnt counts from the rising edge, width DIV_W+8. When vcnt = 8*meas + (meas>>1) - 1, sample rxd_s (stop-bit centre).
    - 1: div=cand, baud counter=cand-1 -> RUN.
    - 0: err=1 -> ARM; div unchanged.
- Baud generator: runs only in RUN.
  - Each cycle the counter decrements. At 0, baud_ref=1 for one cycle and the counter reloads div-1.
  - Outside RUN, baud_ref=0 and the counter holds.
  - First pulse is div cycles after entering RUN.
- cfg_wr, any state:
  - div = max(cfg_div, MIN_DIV); counter = that value minus 1; err=0 -> RUN.
  - cfg_wr has priority over start in the same cycle (start is ignored).
  - cfg_wr during training discards meas and cand.
- start while busy restarts from ARM and clears err.
- busy, rxd_o and err are registered and change the cycle after the state change. rxd_o returns to following rxd_s on the cycle RUN is entered.
- err stays asserted through ARM retries until start or cfg_wr.
- Async reset mid-training returns to RUN with DEF_DIV at once; no pulse is emitted during reset.

Test Plan:
- Reset, no stimulus: baud_ref pulses every 10 clks; div=10; busy=0; rxd_o follows rxd 2 clks later.
- start, then 0x0D sent at 160 clks/bit (8N1):
  - During the char: busy=1, rxd_o=1, no baud_ref.
  - After stop-bit sample: div=10, busy=0, err=0, first baud_ref 10 clks later.
  - A following 0x55 is received correctly by lisa_rx8n.
- start, then 0x0D at 333 clks/bit: div=(333+8)>>4=21; baud_ref period 21.
- start, then rxd held low for 70000 clks (break): err=1 at meas saturation, busy stays 1. Release line, send 0x0D at 160 clks/bit: div=10, err stays 1 until next start.
- start, then 0x0D at 160 clks/bit with rxd forced 0 at the stop-bit centre: err=1, div stays 10, state ARM.
- Three same-cycle/priority cases:
  - cfg_wr with cfg_div=1 and start in the same cycle: div=2 (clamped), state RUN, busy=0, baud_ref every 2 clks.
  - cfg_wr with cfg_div=40 mid-MEAS: training aborted, div=40.
  - rst_n low mid-VERIFY: div=10, baud_ref=0 during reset.
